// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access engine. Decodes load/store ops,
//               runs a req/ack transaction on the data bus, lane-aligns store
//               data and byte enables, formats load data and stalls the
//               pipeline until the access completes or times out.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  mem_opcode,
    input  logic [2:0]  mem_func3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [6:0] c_OP_LOAD       = 7'b0000011;
    localparam logic [6:0] c_OP_STORE      = 7'b0100011;
    localparam logic [1:0] c_IDLE          = 2'd0;
    localparam logic [1:0] c_BUSY          = 2'd1;
    localparam logic [1:0] c_DONE          = 2'd2;
    localparam logic [7:0] c_TIMEOUT_LAST  = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_is_load;
    logic [2:0]  r_func3;
    logic [1:0]  r_off;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_bus_error;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_f3_ok;
    logic        w_addr_misal;
    logic        w_bad;
    logic        w_issue;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_fmt;

    // Decode the held instruction: memory op type, legal func3, alignment
    always_comb begin
        w_is_load    = (mem_opcode == c_OP_LOAD);
        w_is_store   = (mem_opcode == c_OP_STORE);
        w_f3_ok      = 1'b0;
        w_addr_misal = 1'b0;
        if (w_is_load) begin
            case (mem_func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else if (w_is_store) begin
            case (mem_func3)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end
        // func3[1:0] encodes access size for every legal load/store
        if (mem_func3[1:0] == 2'b01) begin
            w_addr_misal = mem_addr[0];
        end else if (mem_func3[1:0] == 2'b10) begin
            w_addr_misal = |mem_addr[1:0];
        end
        w_bad   = (w_is_load | w_is_store) & (~w_f3_ok | w_addr_misal);
        w_issue = (w_is_load | w_is_store) & ~w_bad;
    end

    // Replicate store data across lanes and build the byte-enable mask
    always_comb begin
        w_st_wdata = mem_wdata;
        w_st_be    = 4'b1111;
        case (mem_func3[1:0])
            2'b00: begin
                w_st_wdata = {4{mem_wdata[7:0]}};
                w_st_be    = 4'b0001 << mem_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{mem_wdata[15:0]}};
                w_st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = mem_wdata;
                w_st_be    = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte/halfword from the returned word and extend it
    always_comb begin
        w_byte   = dbus_rdata[{r_off, 3'b000} +: 8];
        w_half   = dbus_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_func3)
            3'b000:  w_ld_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_fmt = {24'd0, w_byte};
            3'b101:  w_ld_fmt = {16'd0, w_half};
            default: w_ld_fmt = dbus_rdata;
        endcase
    end

    // Transaction FSM: issue in IDLE, wait for ack or timeout in BUSY,
    // single release cycle in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= 8'd0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_be         <= 4'd0;
            r_wdata      <= 32'd0;
            r_is_load    <= 1'b0;
            r_func3      <= 3'd0;
            r_off        <= 2'd0;
            r_load_data  <= 32'd0;
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_issue) begin
                        r_req     <= 1'b1;
                        r_we      <= w_is_store;
                        r_addr    <= {mem_addr[31:2], 2'b00};
                        r_be      <= w_is_store ? w_st_be : 4'b1111;
                        r_wdata   <= w_is_store ? w_st_wdata : 32'd0;
                        r_is_load <= w_is_load;
                        r_func3   <= mem_func3;
                        r_off     <= mem_addr[1:0];
                        r_cnt     <= 8'd0;
                        r_state   <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (dbus_ack) begin
                        // An ack in the final wait cycle still completes normally
                        r_req   <= 1'b0;
                        r_state <= c_DONE;
                        if (r_is_load) begin
                            r_load_data  <= w_ld_fmt;
                            r_load_valid <= 1'b1;
                        end
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_req       <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_state     <= c_DONE;
                        if (r_is_load) begin
                            r_load_data  <= 32'd0;
                            r_load_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    // Pipeline advances this cycle, so never re-issue
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Stall covers the issue cycle and every wait cycle; misaligned flags the
    // offending instruction in the same cycle it is presented
    always_comb begin
        stall      = ~reset & (((r_state == c_IDLE) & w_issue) | (r_state == c_BUSY));
        misaligned = ~reset & (r_state == c_IDLE) & w_bad;
    end

    assign dbus_req   = r_req;
    assign dbus_we    = r_we;
    assign dbus_addr  = r_addr;
    assign dbus_be    = r_be;
    assign dbus_wdata = r_wdata;
    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign bus_error  = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  mem_opcode;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Results captured by run_op
    int          res_stall, res_busy, res_lv, res_err;
    bit          res_done, res_unstable, res_we;
    logic [31:0] res_addr, res_wdata, res_ld;
    logic [3:0]  res_be;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_opcode (mem_opcode),
        .mem_func3  (mem_func3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_be    (dbus_be),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata),
        .load_data  (load_data),
        .load_valid (load_valid),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        mem_opcode = OP_ALU;
        mem_func3  = 3'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
    endtask

    // Presents one instruction and plays the bus slave until DONE is seen.
    // ack_after = number of wait cycles before ack (-1 = never ack).
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_after, input logic [31:0] rd,
                          input bit ack_in_done);
        bit seen_req = 0;
        res_stall = 0; res_busy = 0; res_lv = 0; res_err = 0;
        res_done = 0; res_unstable = 0; res_ld = 32'hxxxxxxxx;
        mem_opcode = op; mem_func3 = f3; mem_addr = addr; mem_wdata = wd;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall) res_stall++;
            if (load_valid) begin res_lv++; res_ld = load_data; end
            if (bus_error) res_err++;
            if (dbus_req) begin
                if (!seen_req) begin
                    res_addr = dbus_addr; res_wdata = dbus_wdata;
                    res_be = dbus_be; res_we = dbus_we;
                end else if (res_addr !== dbus_addr || res_wdata !== dbus_wdata ||
                             res_be !== dbus_be || res_we !== dbus_we) begin
                    res_unstable = 1;
                end
                seen_req = 1;
                res_busy++;
                dbus_ack   = (res_busy == ack_after + 1);
                dbus_rdata = dbus_ack ? rd : 32'hDEADBEEF;
            end else if (seen_req) begin
                res_done   = 1;
                dbus_ack   = ack_in_done;
                dbus_rdata = 32'hFFFFFFFF;
                step();
                dbus_ack = 1'b0;
                clear_op();
                break;
            end else begin
                dbus_ack = 1'b0;
            end
            step();
        end
        if (!res_done) begin
            dbus_ack = 1'b0;
            clear_op();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0; clear_op();
        step(); step();
        reset = 1'b0;
        #1;
        n_checks++; if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", dbus_req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall); end
        n_checks++; if (load_data !== 32'd0) begin n_fail++; $display("FAIL rst_load_data: got %h expected 0", load_data); end
        n_checks++; if ({load_valid, misaligned, bus_error, dbus_we, dbus_be} !== 7'd0) begin n_fail++; $display("FAIL rst_pulses: got %b expected 0", {load_valid, misaligned, bus_error, dbus_we, dbus_be}); end
        step();
    endtask

    task automatic test_store_byte();
        run_op(OP_ST, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2, 32'd0, 0);
        n_checks++; if (res_done !== 1'b1) begin n_fail++; $display("FAIL sb_done: got %b expected 1", res_done); end
        n_checks++; if (res_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b expected 1000", res_be); end
        n_checks++; if (res_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", res_wdata); end
        n_checks++; if (res_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h expected 00001000", res_addr); end
        n_checks++; if (res_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b expected 1", res_we); end
        n_checks++; if (res_stall !== 4) begin n_fail++; $display("FAIL sb_stall: got %0d expected 4", res_stall); end
        n_checks++; if (res_busy !== 3 || res_unstable) begin n_fail++; $display("FAIL sb_busy: got %0d/unstable=%b expected 3/0", res_busy, res_unstable); end
        n_checks++; if (res_lv !== 0 || res_err !== 0) begin n_fail++; $display("FAIL sb_pulses: got lv=%0d err=%0d expected 0/0", res_lv, res_err); end
    endtask

    task automatic test_store_half();
        run_op(OP_ST, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 32'd0, 0);
        n_checks++; if (res_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b expected 1100", res_be); end
        n_checks++; if (res_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h expected abcdabcd", res_wdata); end
        n_checks++; if (res_stall !== 2) begin n_fail++; $display("FAIL sh_stall: got %0d expected 2", res_stall); end
    endtask

    task automatic test_load_byte();
        run_op(OP_LD, 3'b000, 32'h0000_2001, 32'd0, 0, 32'h0000_8000, 0);
        n_checks++; if (res_ld !== 32'hFFFFFF80 || res_lv !== 1) begin n_fail++; $display("FAIL lb_data: got %h lv=%0d expected ffffff80 lv=1", res_ld, res_lv); end
        n_checks++; if (res_we !== 1'b0 || res_be !== 4'b1111 || res_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lb_bus: got we=%b be=%b addr=%h expected 0/1111/00002000", res_we, res_be, res_addr); end
        #1;
        n_checks++; if (load_valid !== 1'b0 || load_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_hold: got lv=%b data=%h expected 0/ffffff80", load_valid, load_data); end
        run_op(OP_LD, 3'b100, 32'h0000_2001, 32'd0, 1, 32'h0000_8000, 0);
        n_checks++; if (res_ld !== 32'h00000080 || res_lv !== 1) begin n_fail++; $display("FAIL lbu_data: got %h lv=%0d expected 00000080 lv=1", res_ld, res_lv); end
    endtask

    task automatic test_load_half_word();
        run_op(OP_LD, 3'b001, 32'h0000_2002, 32'd0, 0, 32'hBEEF_1234, 0);
        n_checks++; if (res_ld !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh_data: got %h expected ffffbeef", res_ld); end
        run_op(OP_LD, 3'b101, 32'h0000_2000, 32'd0, 0, 32'h1234_F00D, 0);
        n_checks++; if (res_ld !== 32'h0000F00D) begin n_fail++; $display("FAIL lhu_data: got %h expected 0000f00d", res_ld); end
        run_op(OP_LD, 3'b010, 32'h0000_2004, 32'd0, 1, 32'h8765_4321, 0);
        n_checks++; if (res_ld !== 32'h87654321 || res_stall !== 3) begin n_fail++; $display("FAIL lw_data: got %h stall=%0d expected 87654321 stall=3", res_ld, res_stall); end
    endtask

    task automatic test_misaligned();
        mem_opcode = OP_LD; mem_func3 = 3'b010; mem_addr = 32'h0000_2001;
        #1;
        n_checks++; if (misaligned !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL mis_lw: got mis=%b stall=%b expected 1/0", misaligned, stall); end
        step(); clear_op(); #1;
        n_checks++; if (dbus_req !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_lw_after: got req=%b mis=%b expected 0/0", dbus_req, misaligned); end
        step();
        mem_opcode = OP_ST; mem_func3 = 3'b011; mem_addr = 32'h0000_3000;
        #1;
        n_checks++; if (misaligned !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL mis_illegal_f3: got mis=%b stall=%b expected 1/0", misaligned, stall); end
        step(); clear_op();
        mem_opcode = 7'b0110011; mem_func3 = 3'b001; mem_addr = 32'h0000_0001;
        #1;
        n_checks++; if (misaligned !== 1'b0 || stall !== 1'b0 || dbus_req !== 1'b0) begin n_fail++; $display("FAIL nonmem: got mis=%b stall=%b req=%b expected 0/0/0", misaligned, stall, dbus_req); end
        step(); clear_op(); #1;
        n_checks++; if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL nonmem_req: got %b expected 0", dbus_req); end
        step();
    endtask

    task automatic test_timeout();
        run_op(OP_LD, 3'b010, 32'h0000_3000, 32'd0, -1, 32'd0, 0);
        n_checks++; if (res_busy !== 16 || res_stall !== 17) begin n_fail++; $display("FAIL to_cycles: got busy=%0d stall=%0d expected 16/17", res_busy, res_stall); end
        n_checks++; if (res_err !== 1 || res_lv !== 1 || res_ld !== 32'd0) begin n_fail++; $display("FAIL to_pulses: got err=%0d lv=%0d data=%h expected 1/1/0", res_err, res_lv, res_ld); end
        #1;
        n_checks++; if (bus_error !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL to_after: got err=%b stall=%b expected 0/0", bus_error, stall); end
        run_op(OP_LD, 3'b010, 32'h0000_3004, 32'd0, 15, 32'h0BAD_F00D, 0);
        n_checks++; if (res_err !== 0 || res_busy !== 16 || res_ld !== 32'h0BADF00D) begin n_fail++; $display("FAIL to_ack_wins: got err=%0d busy=%0d data=%h expected 0/16/0badf00d", res_err, res_busy, res_ld); end
    endtask

    task automatic test_back_to_back();
        run_op(OP_ST, 3'b010, 32'h0000_0040, 32'hCAFE_BABE, 0, 32'd0, 1);
        n_checks++; if (res_stall !== 2 || res_busy !== 1) begin n_fail++; $display("FAIL b2b_sw_stall: got stall=%0d busy=%0d expected 2/1", res_stall, res_busy); end
        n_checks++; if (res_wdata !== 32'hCAFEBABE || res_be !== 4'b1111 || res_we !== 1'b1) begin n_fail++; $display("FAIL b2b_sw_bus: got %h be=%b we=%b expected cafebabe/1111/1", res_wdata, res_be, res_we); end
        run_op(OP_LD, 3'b010, 32'h0000_0044, 32'd0, 0, 32'h1357_9BDF, 1);
        n_checks++; if (res_stall !== 2 || res_busy !== 1 || res_addr !== 32'h0000_0044) begin n_fail++; $display("FAIL b2b_lw_req: got stall=%0d busy=%0d addr=%h expected 2/1/00000044", res_stall, res_busy, res_addr); end
        n_checks++; if (res_ld !== 32'h13579BDF || res_lv !== 1) begin n_fail++; $display("FAIL b2b_lw_data: got %h lv=%0d expected 13579bdf/1", res_ld, res_lv); end
        #1;
        n_checks++; if (dbus_req !== 1'b0 || load_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_no_reissue: got req=%b lv=%b stall=%b expected 0/0/0", dbus_req, load_valid, stall); end
        step();
        n_checks++; if (dbus_req !== 1'b0 || load_data !== 32'h13579BDF) begin n_fail++; $display("FAIL b2b_idle: got req=%b data=%h expected 0/13579bdf", dbus_req, load_data); end
    endtask

    task automatic test_reset_mid();
        mem_opcode = OP_LD; mem_func3 = 3'b010; mem_addr = 32'h0000_5000;
        step(); #1;
        n_checks++; if (dbus_req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got req=%b stall=%b expected 1/1", dbus_req, stall); end
        reset = 1'b1; clear_op();
        step(); step();
        reset = 1'b0;
        #1;
        n_checks++; if (dbus_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_state: got req=%b stall=%b data=%h expected 0/0/0", dbus_req, stall, load_data); end
        step();
        n_checks++; if ({dbus_req, load_valid, bus_error, misaligned} !== 4'd0) begin n_fail++; $display("FAIL rstmid_quiet: got %b expected 0000", {dbus_req, load_valid, bus_error, misaligned}); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half();
        test_load_byte();
        test_load_half_word();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
